// File: rtl/muxn_reg_rr.sv
// Registered N-way multiplexer with valid/ready handshake.
// In fixed mode an external select picks the source. In round-robin mode the
// first valid channel at or after the rotating pointer wins. The output
// register refills only when it is empty or is being consumed.
module muxn_reg_rr #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 2,
    localparam int NUM_IN = 2 ** SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    rr_mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_act;
    logic             load;
    logic             xfer;

    // Grant selection: the external select in fixed mode, otherwise a scan
    // that starts at ptr and wraps through the channel indices.
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand      = '0;
        grant_act = 1'b0;
        grant_idx = '0;
        if (!rr_mode) begin
            grant_idx = sel;
            grant_act = in_valid[sel];
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                cand = ptr + SEL_W'(k);
                if (!grant_act && in_valid[cand]) begin
                    grant_act = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Handshake: ready goes only to the granted channel, and only when the
    // output register can take a word. Held low during reset.
    always_comb begin
        load     = !out_valid || out_ready;
        in_ready = '0;
        if (rst_n && grant_act) begin
            in_ready[grant_idx] = load;
        end
        xfer = rst_n && grant_act && load;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
            out_src   <= grant_idx;
            out_valid <= 1'b1;
            if (rr_mode) begin
                ptr <= grant_idx + SEL_W'(1);
            end
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_reg_rr.sv
// Self-checking bench for muxn_reg_rr: a reference model predicts in_ready
// each cycle and queues the word that should be captured; the queue is popped
// and compared after the capturing edge.
module tb_muxn_reg_rr;

    localparam int WIDTH  = 16;
    localparam int SEL_W  = 2;
    localparam int NUM_IN = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic                    rr_mode;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;

    muxn_reg_rr #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .rr_mode   (rr_mode),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    logic [SEL_W-1:0] m_src   = '0;
    int               m_ptr   = 0;
    logic [WIDTH+SEL_W-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Backward scan so the last hit is the one nearest ptr.
    function automatic void mgrant(output bit act, output int g);
        act = 1'b0;
        g   = 0;
        if (!rr_mode) begin
            g   = int'(sel);
            act = in_valid[sel];
        end else begin
            for (int d = NUM_IN - 1; d >= 0; d--) begin
                int c;
                c = (m_ptr + d) % NUM_IN;
                if (in_valid[c]) begin
                    act = 1'b1;
                    g   = c;
                end
            end
        end
    endfunction

    task automatic step();
        bit act;
        int g;
        bit ld;
        bit xfer;
        bit mode;
        logic [NUM_IN-1:0] er;
        logic [WIDTH+SEL_W-1:0] w;
        #1;
        mgrant(act, g);
        ld   = !m_valid || out_ready;
        xfer = rst_n && act && ld;
        er   = xfer ? NUM_IN'(1 << g) : '0;
        mode = rr_mode;
        chk("in_ready", 32'(in_ready), 32'(er));
        if (xfer) sb.push_back({in_data[g*WIDTH +: WIDTH], SEL_W'(g)});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = '0;
            m_ptr   = 0;
            sb.delete();
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            chk("rst_src", 32'(out_src), 32'd0);
        end else if (xfer) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                w = sb.pop_front();
                m_data  = w[WIDTH+SEL_W-1:SEL_W];
                m_src   = w[SEL_W-1:0];
                m_valid = 1'b1;
                if (mode) m_ptr = (g + 1) % NUM_IN;
                chk("xfer_data", 32'(out_data), 32'(m_data));
                chk("xfer_src", 32'(out_src), 32'(m_src));
                chk("xfer_valid", 32'(out_valid), 32'd1);
            end
        end else begin
            if (ld) m_valid = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'(m_valid));
            chk("hold_data", 32'(out_data), 32'(m_data));
            chk("hold_src", 32'(out_src), 32'(m_src));
        end
    endtask

    task automatic set_all_data(input logic [WIDTH-1:0] base);
        for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        rr_mode   = 1'b0;
        out_ready = 1'b0;
        #2;
        in_valid = '1;
        step();
        step();

        // fixed mode, channel 2
        rst_n     = 1'b1;
        in_valid  = 4'b0000;
        step();
        sel       = 2'd2;
        in_valid  = 4'b0100;
        in_data[2*WIDTH +: WIDTH] = 16'hBEEF;
        out_ready = 1'b1;
        step();
        chk("beef_data", 32'(out_data), 32'h0000BEEF);
        chk("beef_src", 32'(out_src), 32'd2);

        // backpressure with changing data
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data[2*WIDTH +: WIDTH] = 16'hC000 + 16'(i);
            step();
            chk("bp_stable", 32'(out_data), 32'h0000BEEF);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", 32'(out_data), 32'h0000C002);
        in_valid = 4'b0000;
        step();

        // round-robin, all valid
        rr_mode  = 1'b1;
        in_valid = 4'b1111;
        set_all_data(16'h1000);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_seq", 32'(out_src), 32'(i % NUM_IN));
        end

        // sparse valids, ptr back at 0
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_sparse", 32'(out_src), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) step();

        // ptr now 2; fixed excursion must not move it
        rr_mode  = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0001;
        step();
        step();
        rr_mode  = 1'b1;
        in_valid = 4'b1111;
        step();
        chk("rr_resume", 32'(out_src), 32'd2);

        // reset mid-stall
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_ptr", 32'(out_src), 32'd0);

        // random mix
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < NUM_IN; c++) in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
            in_valid  = NUM_IN'($urandom);
            sel       = SEL_W'($urandom);
            rr_mode   = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
